nx_axi4s_frame_rx: RTL and testbench
====================================

// Module: nx_axi4s_frame_rx
// PURPOSE
//  Host-side receiver for the slot-packed Nexus AXI4-stream: unpacks each beat into
//  individual nx_message_t messages, marks the final message of every TLAST frame,
//  reports per-frame message counts, and flags packing-protocol violations.
//  Sits between the host DMA/AXI4-stream fabric and host-side message consumers.
// PARAMETERS
//  AXI4_DATA_WIDTH  64  beat width; A2N_RATIO = AXI4_DATA_WIDTH / (MSG_WIDTH+1) slots, must be >= 1
//  CNT_WIDTH        16  width of per-frame message counter / frame_len_o
// PORTS
//  clk_i              in   1                single clock
//  rst_i              in   1                synchronous, active-high reset
//  ib_axi4s_tdata_i   in   AXI4_DATA_WIDTH  slot i = bits [i*SW +: SW], SW=MSG_WIDTH+1; slot MSB = present
//  ib_axi4s_tlast_i   in   1                final beat of frame
//  ib_axi4s_tvalid_i  in   1                beat valid
//  ib_axi4s_tready_o  out  1                beat accepted when tvalid && tready
//  ob_nx_data_o       out  MSG_WIDTH        unpacked message (nx_message_t)
//  ob_nx_last_o       out  1                message is final present slot of a TLAST beat
//  ob_nx_valid_o      out  1                message valid
//  ob_nx_ready_i      in   1                consumer accepts when valid && ready
//  frame_done_o       out  1                1-cycle pulse: frame completed
//  frame_len_o        out  CNT_WIDTH        messages in completed frame (valid with frame_done_o)
//  err_noncontig_o    out  1                sticky: present slot found above an absent slot
//  err_empty_o        out  1                sticky: beat with no present slots and TLAST low
//  err_clr_i          in   1                clears both sticky errors
// BEHAVIOUR
//  Reset: tready_o=1; ob_nx_valid/last=0, ob_nx_data=0; frame_done=0, frame_len=0;
//   both errors=0; slot pointer=0; frame counter=0; beat register empty. Mid-frame reset
//   discards held beat and partial count; no frame_done is emitted for it.
//  States: IDLE (beat reg empty, tready_o=1) / UNPACK (beat held, tready_o=0).
//   IDLE->UNPACK on tvalid; UNPACK->IDLE in the cycle the final emitted slot is loaded.
//  Valid slots = contiguous run of present bits from slot 0 up to first absent slot;
//   slots above first absent are discarded; any present bit among them sets err_noncontig.
//  UNPACK: when !ob_nx_valid_o || ob_nx_ready_i, load slot[ptr] into output regs, ptr++;
//   ob_nx_last = tlast && (ptr is last valid slot). Ptr returns to 0 on beat release.
//  Latency: beat accepted cycle N -> slot 0 on outputs at N+2, slot k at N+2+k with
//   ready held high; beat of P valid slots releases at end of N+P, next accept at N+P+1.
//  Output regs hold data/last stable while valid && !ready (no combinational ready path).
//  Frame counter increments per emitted message, saturates at 2^CNT_WIDTH-1.
//   frame_done_o pulses in the same cycle the ob_nx_last message first appears valid;
//   frame_len_o = count including that message; counter then resets to 0.
//  Empty beat (no present slots): if tlast, frame_done pulses at N+2 with current count
//   (may be 0), no message emitted; if !tlast, set err_empty; beat dropped either way.
//  err_clr_i and a new error in the same cycle: error set wins.
//  frame_len_o holds last value between pulses.
// TESTING (bench sets AXI4_DATA_WIDTH so A2N_RATIO >= 3)
//  1 Beat present=3'b011, tlast=1, ready=1 -> msgs slot0,slot1 at N+2,N+3; last on slot1;
//    frame_done at N+3, frame_len=2; tready_o low N+1..N+2.
//  2 Two beats present=3'b111 tlast=0 then 3'b001 tlast=1 -> 4 msgs in order, last only on 4th,
//    frame_len=4, no frame_done after first beat.
//  3 Beat present=3'b101 -> only slot0 emitted, err_noncontig=1; err_clr_i pulse -> 0.
//  4 ready low 5 cycles with msg valid -> data/last stable, tready_o stays 0, no loss.
//  5 Empty beat tlast=0 -> err_empty=1, nothing emitted; empty beat tlast=1 -> frame_done, len=0.
//  6 rst_i asserted mid-beat -> all outputs at reset values next cycle; next frame counts from 0.

Source files
------------

// File: rtl/nx_axi4s_frame_rx.sv
// nx_axi4s_frame_rx
//   Host-side receiver for the slot-packed Nexus AXI4-stream. Each accepted
//   beat carries A2N_RATIO slots of SW = MSG_WIDTH+1 bits; the slot MSB is a
//   present flag. The beat is held while its contiguous run of present slots
//   (starting at slot 0) is unpacked one message per cycle onto the nx side.
//   Per-frame message counts are reported on frame_done_o/frame_len_o, and
//   packing violations are flagged as sticky errors.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   ib_axi4s_tdata_i    packed beat, slot i = bits [i*SW +: SW]
//   ib_axi4s_tlast_i    final beat of frame
//   ib_axi4s_tvalid_i   beat valid
//   ib_axi4s_tready_o   high while no beat is held
//   ob_nx_data_o        unpacked message
//   ob_nx_last_o        final message of a TLAST beat
//   ob_nx_valid_o       message valid
//   ob_nx_ready_i       consumer ready
//   frame_done_o        1-cycle pulse per completed frame
//   frame_len_o         message count of the completed frame (held between pulses)
//   err_noncontig_o     sticky: present slot above an absent slot
//   err_empty_o         sticky: beat with no present slot and TLAST low
//   err_clr_i           clears both sticky errors (a simultaneous new error wins)
module nx_axi4s_frame_rx #(
  parameter int AXI4_DATA_WIDTH = 64,
  parameter int MSG_WIDTH       = 20,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [AXI4_DATA_WIDTH-1:0] ib_axi4s_tdata_i,
  input  logic                       ib_axi4s_tlast_i,
  input  logic                       ib_axi4s_tvalid_i,
  output logic                       ib_axi4s_tready_o,
  output logic [MSG_WIDTH-1:0]       ob_nx_data_o,
  output logic                       ob_nx_last_o,
  output logic                       ob_nx_valid_o,
  input  logic                       ob_nx_ready_i,
  output logic                       frame_done_o,
  output logic [CNT_WIDTH-1:0]       frame_len_o,
  output logic                       err_noncontig_o,
  output logic                       err_empty_o,
  input  logic                       err_clr_i
);

  localparam int SW        = MSG_WIDTH + 1;
  localparam int A2N_RATIO = AXI4_DATA_WIDTH / SW;
  localparam int USED_W    = A2N_RATIO * SW;
  localparam int PTR_W     = (A2N_RATIO > 1) ? $clog2(A2N_RATIO) : 1;
  localparam int NV_W      = $clog2(A2N_RATIO + 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_UNPACK = 1'b1
  } state_t;

  state_t                r_state;
  logic [USED_W-1:0]     r_beat;
  logic                  r_tlast;
  logic [NV_W-1:0]       r_nvalid;
  logic [PTR_W-1:0]      r_ptr;
  logic [MSG_WIDTH-1:0]  r_data;
  logic                  r_last;
  logic                  r_valid;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  r_len;
  logic                  r_done;
  logic                  r_err_nc;
  logic                  r_err_empty;

  logic [A2N_RATIO-1:0]  w_present;
  logic [MSG_WIDTH-1:0]  w_slots [A2N_RATIO];
  logic [NV_W-1:0]       w_in_nvalid;
  logic                  w_in_noncontig;
  logic                  w_accept;
  logic                  w_load;
  logic                  w_final_slot;
  logic [NV_W-1:0]       w_ptr_ext;
  logic [CNT_WIDTH-1:0]  w_cnt_inc;
  logic [MSG_WIDTH-1:0]  w_slot_data;

  // Present flags come from the incoming beat; payloads from the held beat.
  for (genvar g = 0; g < A2N_RATIO; g++) begin : g_slot
    assign w_present[g] = ib_axi4s_tdata_i[g*SW + MSG_WIDTH];
    assign w_slots[g]   = r_beat[g*SW +: MSG_WIDTH];
  end

  // Valid slots are the run of present flags from slot 0 up to the first
  // absent slot; any present flag beyond that gap is a packing violation.
  always_comb begin
    logic gap;
    gap            = 1'b0;
    w_in_nvalid    = '0;
    w_in_noncontig = 1'b0;
    for (int unsigned i = 0; i < A2N_RATIO; i++) begin
      if (w_present[i]) begin
        if (gap) w_in_noncontig = 1'b1;
        else     w_in_nvalid    = w_in_nvalid + 1'b1;
      end else begin
        gap = 1'b1;
      end
    end
  end

  assign w_accept     = (r_state == ST_IDLE) && ib_axi4s_tvalid_i;
  assign w_load       = (r_state == ST_UNPACK) && (r_nvalid != '0) &&
                        (!r_valid || ob_nx_ready_i);
  assign w_ptr_ext    = NV_W'(r_ptr);
  assign w_final_slot = ((w_ptr_ext + 1'b1) == r_nvalid);
  assign w_cnt_inc    = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_slot_data  = w_slots[r_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_beat      <= '0;
      r_tlast     <= 1'b0;
      r_nvalid    <= '0;
      r_ptr       <= '0;
      r_data      <= '0;
      r_last      <= 1'b0;
      r_valid     <= 1'b0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_done      <= 1'b0;
      r_err_nc    <= 1'b0;
      r_err_empty <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_accept) begin
        r_beat   <= ib_axi4s_tdata_i[USED_W-1:0];
        r_tlast  <= ib_axi4s_tlast_i;
        r_nvalid <= w_in_nvalid;
        r_ptr    <= '0;
        r_state  <= ST_UNPACK;
      end

      if (r_state == ST_UNPACK) begin
        if (r_nvalid == '0) begin
          // Empty beat: dropped after one cycle; a TLAST still closes the
          // frame with whatever has been counted so far.
          r_state <= ST_IDLE;
          if (r_tlast) begin
            r_done <= 1'b1;
            r_len  <= r_cnt;
            r_cnt  <= '0;
          end
        end else if (w_load) begin
          if (w_final_slot) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
      end

      // frame_done is registered alongside the last message so both become
      // visible in the same cycle.
      if (w_load) begin
        r_data  <= w_slot_data;
        r_last  <= r_tlast && w_final_slot;
        r_valid <= 1'b1;
        if (r_tlast && w_final_slot) begin
          r_done <= 1'b1;
          r_len  <= w_cnt_inc;
          r_cnt  <= '0;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end else if (ob_nx_ready_i) begin
        r_valid <= 1'b0;
      end

      if (err_clr_i) begin
        r_err_nc    <= 1'b0;
        r_err_empty <= 1'b0;
      end
      if (w_accept) begin
        if (w_in_noncontig) r_err_nc <= 1'b1;
        if ((w_in_nvalid == '0) && !ib_axi4s_tlast_i) r_err_empty <= 1'b1;
      end
    end
  end

  assign ib_axi4s_tready_o = (r_state == ST_IDLE);
  assign ob_nx_data_o      = r_data;
  assign ob_nx_last_o      = r_last;
  assign ob_nx_valid_o     = r_valid;
  assign frame_done_o      = r_done;
  assign frame_len_o       = r_len;
  assign err_noncontig_o   = r_err_nc;
  assign err_empty_o       = r_err_empty;

endmodule

// File: tb/tb_nx_axi4s_frame_rx.sv
// Testbench for nx_axi4s_frame_rx: directed beats with a queue-based
// reference model of the unpacking, frame counting and error flags.
module tb_nx_axi4s_frame_rx;

  localparam int DW = 64;
  localparam int MW = 20;
  localparam int SW = MW + 1;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] tdata = '0;
  logic          tlast = 1'b0;
  logic          tvalid = 1'b0;
  logic          tready;
  logic [MW-1:0] nx_data;
  logic          nx_last;
  logic          nx_valid;
  logic          nx_ready = 1'b1;
  logic          frame_done;
  logic [CW-1:0] frame_len;
  logic          err_nc;
  logic          err_empty;
  logic          err_clr = 1'b0;

  nx_axi4s_frame_rx #(
    .AXI4_DATA_WIDTH(DW),
    .MSG_WIDTH      (MW),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .ib_axi4s_tdata_i (tdata),
    .ib_axi4s_tlast_i (tlast),
    .ib_axi4s_tvalid_i(tvalid),
    .ib_axi4s_tready_o(tready),
    .ob_nx_data_o     (nx_data),
    .ob_nx_last_o     (nx_last),
    .ob_nx_valid_o    (nx_valid),
    .ob_nx_ready_i    (nx_ready),
    .frame_done_o     (frame_done),
    .frame_len_o      (frame_len),
    .err_noncontig_o  (err_nc),
    .err_empty_o      (err_empty),
    .err_clr_i        (err_clr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [DW-1:0] mk(input logic [2:0] pres, input logic [MW-1:0] m0,
                                       input logic [MW-1:0] m1, input logic [MW-1:0] m2);
    logic [DW-1:0] d;
    d = '0;
    d[0  +: MW] = m0;  d[MW]        = pres[0];
    d[SW +: MW] = m1;  d[SW + MW]   = pres[1];
    d[2*SW +: MW] = m2; d[2*SW + MW] = pres[2];
    d[DW-1] = 1'b1;  // padding bit, must be ignored
    return d;
  endfunction

  // Reference model state
  logic [MW:0] exp_msg [$];  // {last, data}
  int          exp_len [$];
  int          m_cnt = 0;
  bit          m_nc = 0;
  bit          m_empty = 0;
  bit          prev_hold = 0;
  logic [MW-1:0] prev_data;
  logic        prev_last;

  task automatic model_accept(input logic [DW-1:0] d, input logic l);
    int p;
    bit gap;
    bit nc;
    p = 0; gap = 0; nc = 0;
    for (int i = 0; i < 3; i++) begin
      if (d[i*SW + MW]) begin
        if (gap) nc = 1; else p++;
      end else begin
        gap = 1;
      end
    end
    for (int k = 0; k < p; k++) begin
      exp_msg.push_back({(l && (k == p - 1)), d[k*SW +: MW]});
      if (m_cnt < 65535) m_cnt++;
    end
    if (l) begin
      exp_len.push_back(m_cnt);
      m_cnt = 0;
    end
    if (nc) m_nc = 1;
    if (p == 0 && !l) m_empty = 1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_msg.delete();
      exp_len.delete();
      m_cnt = 0; m_nc = 0; m_empty = 0; prev_hold = 0;
    end else begin
      check("err_noncontig", err_nc, m_nc);
      check("err_empty", err_empty, m_empty);
      if (prev_hold) begin
        check("hold_valid", nx_valid, 1'b1);
        check("hold_data", nx_data, prev_data);
        check("hold_last", nx_last, prev_last);
      end
      if (nx_valid && nx_last && !prev_hold) check("last_with_done", frame_done, 1'b1);
      if (nx_valid && nx_ready) begin
        if (exp_msg.size() == 0) fail_now("unexpected_msg");
        else begin
          logic [MW:0] e;
          e = exp_msg.pop_front();
          check("msg_data", nx_data, e[MW-1:0]);
          check("msg_last", nx_last, e[MW]);
        end
      end
      if (frame_done) begin
        done_seen++;
        if (exp_len.size() == 0) fail_now("unexpected_frame_done");
        else begin
          int l;
          l = exp_len.pop_front();
          check("frame_len", frame_len, l);
          if (l != 0) check("done_with_last", nx_valid && nx_last, 1'b1);
        end
      end
      if (err_clr) begin m_nc = 0; m_empty = 0; end
      if (tvalid && tready) model_accept(tdata, tlast);
      prev_hold = nx_valid && !nx_ready;
      prev_data = nx_data;
      prev_last = nx_last;
    end
  end

  task automatic send(input logic [2:0] pres, input logic [MW-1:0] m0, input logic [MW-1:0] m1,
                      input logic [MW-1:0] m2, input logic l);
    int n;
    tdata = mk(pres, m0, m1, m2);
    tlast = l;
    tvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!tready) fail_now("send_timeout");
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!frame_done && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!frame_done) fail_now(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tready", tready, 1'b1);
    check("rst_valid", nx_valid, 1'b0);
    check("rst_last", nx_last, 1'b0);
    check("rst_data", nx_data, '0);
    check("rst_done", frame_done, 1'b0);
    check("rst_len", frame_len, '0);

    // 1: present=011, tlast=1
    @(posedge clk); #1;
    tdata = mk(3'b011, 20'hA1111, 20'hB2222, 20'hC3333);
    tlast = 1'b1; tvalid = 1'b1;
    @(negedge clk);
    check("t1_tready_N", tready, 1'b1);
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0;
    @(negedge clk);
    check("t1_tready_N1", tready, 1'b0);
    check("t1_valid_N1", nx_valid, 1'b0);
    @(negedge clk);
    check("t1_tready_N2", tready, 1'b0);
    check("t1_valid_N2", nx_valid, 1'b1);
    check("t1_data_N2", nx_data, 20'hA1111);
    check("t1_last_N2", nx_last, 1'b0);
    check("t1_done_N2", frame_done, 1'b0);
    @(negedge clk);
    check("t1_tready_N3", tready, 1'b1);
    check("t1_data_N3", nx_data, 20'hB2222);
    check("t1_last_N3", nx_last, 1'b1);
    check("t1_done_N3", frame_done, 1'b1);
    check("t1_len_N3", frame_len, 16'd2);
    idle(3);

    // 2: two beats, one frame of 4
    d0 = done_seen;
    send(3'b111, 20'h00001, 20'h00002, 20'h00003, 1'b0);
    send(3'b001, 20'h00004, 20'hFFFFF, 20'hEEEEE, 1'b1);
    idle(8);
    check("t2_frames", done_seen - d0, 1);
    check("t2_len", frame_len, 16'd4);

    // 3: non-contiguous packing
    send(3'b101, 20'h12345, 20'h0BAD0, 20'h0BAD1, 1'b1);
    idle(5);
    check("t3_err_nc", err_nc, 1'b1);
    check("t3_len", frame_len, 16'd1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    @(negedge clk);
    check("t3_err_nc_clr", err_nc, 1'b0);

    // 4: consumer stall with message pending
    idle(1);
    nx_ready = 1'b0;
    send(3'b111, 20'h55555, 20'h66666, 20'h77777, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_tready", tready, 1'b0);
      check("t4_valid", nx_valid, 1'b1);
      check("t4_data", nx_data, 20'h55555);
    end
    @(posedge clk); #1;
    nx_ready = 1'b1;
    idle(6);
    check("t4_len", frame_len, 16'd3);

    // 5: empty beats
    send(3'b000, 20'h11111, 20'h22222, 20'h33333, 1'b0);
    idle(3);
    check("t5_err_empty", err_empty, 1'b1);
    check("t5_valid", nx_valid, 1'b0);
    send(3'b000, 20'h11111, 20'h22222, 20'h33333, 1'b1);
    wait_done("t5_done_timeout");
    check("t5_len0", frame_len, 16'd0);
    idle(2);

    // 6: reset in the middle of a beat
    send(3'b111, 20'h0AAAA, 20'h0BBBB, 20'h0CCCC, 1'b0);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    check("t6_valid", nx_valid, 1'b0);
    check("t6_last", nx_last, 1'b0);
    check("t6_data", nx_data, '0);
    check("t6_done", frame_done, 1'b0);
    check("t6_len", frame_len, '0);
    check("t6_err_empty", err_empty, 1'b0);
    check("t6_tready", tready, 1'b1);
    @(posedge clk); #1;
    send(3'b011, 20'h0DDDD, 20'h0EEEE, 20'h0FFFF, 1'b1);
    wait_done("t6_done_timeout");
    check("t6_len_after", frame_len, 16'd2);

    idle(10);
    check("end_msgs_left", exp_msg.size(), 0);
    check("end_frames_left", exp_len.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
